// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_unit: instruction fetch front end with a small in-order fetch buffer.
//
// Issues word-aligned fetch requests to instruction memory, pairs each in-order response with
// the address that produced it, and presents the oldest buffered {pc, instr} pair to IF/ID.
// A redirect restarts fetch at the new target, empties the buffer and drops every response
// still owed by memory for the old path.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, a redirect with redirect_pc_i[1:0] != 0 raises the sticky fetch_fault_o and
//   stops all further fetch until reset. When undefined, the low bits are silently cleared and
//   fetch_fault_o does not exist.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     fetch buffer capacity; bound on outstanding + buffered entries
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req_valid_o/addr_o  fetch request toward instruction memory
//   imem_req_ready_i         memory accepts the request this cycle
//   imem_rsp_valid_i/data_i  in-order instruction word return (latency >= 1)
//   redirect_valid_i/pc_i    branch/jump redirect from a later stage
//   id_valid_o/id_ready_i    handshake toward the IF/ID register
//   id_pc_o/id_instr_o       oldest buffered pc/instruction
//   fetch_fault_o            sticky misaligned-redirect flag (MISALIGN_TRAP_EN only)
// ---------------------------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault_o
`endif
);

  localparam int unsigned   PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CntW     = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW:0]   OccMax  = (CntW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CntW-1:0]  osd_q, osd_d;     // requests accepted but not yet answered
  logic [CntW-1:0]  drop_q, drop_d;   // old-path responses still to be discarded
  logic [PtrW-1:0]  aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [PtrW-1:0]  b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [CntW-1:0]  b_cnt_q, b_cnt_d;

  // Address queue of outstanding requests and the {pc, instr} fetch buffer.
  logic [31:0] aq_mem [DEPTH];
  logic [31:0] bp_mem [DEPTH];
  logic [31:0] bi_mem [DEPTH];

  logic        fault_q;
  logic        misalign;
  logic [31:0] redirect_aligned;
  logic        req_fire, rsp_hit, drop_hit, pop;
  logic        aq_we, b_we;
  logic [CntW-1:0] osd_nxt;
  logic [CntW:0]   occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign misalign         = |redirect_pc_i[1:0];
  assign redirect_aligned = {redirect_pc_i[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Misaligned-redirect trap
  // ---------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
  logic fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid_i && misalign) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault_o = fault_q;
`else
  logic unused_misalign;
  assign fault_q         = 1'b0;
  assign unused_misalign = misalign;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign occupancy        = {1'b0, osd_q} + {1'b0, b_cnt_q};
  assign imem_req_valid_o = (state_q == StRun) && (occupancy < OccMax) && !fault_q;
  assign imem_req_addr_o  = pc_q;

  assign id_valid_o = (b_cnt_q != '0);
  assign id_pc_o    = bp_mem[b_rd_q];
  assign id_instr_o = bi_mem[b_rd_q];

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  // Responses with nothing outstanding (e.g. stale ones after reset) are ignored.
  assign rsp_hit  = imem_rsp_valid_i && (state_q == StRun) && (osd_q != '0);
  assign drop_hit = imem_rsp_valid_i && (state_q == StFlush) && (drop_q != '0);
  assign pop      = id_valid_o && id_ready_i && !redirect_valid_i;
  assign osd_nxt  = osd_q + CntW'(req_fire) - CntW'(rsp_hit);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    osd_d   = osd_nxt;
    drop_d  = drop_q;
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;
    b_wr_d  = b_wr_q;
    b_rd_d  = b_rd_q;
    b_cnt_d = b_cnt_q + CntW'(rsp_hit) - CntW'(pop);
    aq_we   = 1'b0;
    b_we    = 1'b0;

    if (req_fire) begin
      aq_we   = 1'b1;
      aq_wr_d = ptr_inc(aq_wr_q);
      pc_d    = pc_q + 32'd4;
    end
    if (rsp_hit) begin
      aq_rd_d = ptr_inc(aq_rd_q);
      b_we    = 1'b1;
      b_wr_d  = ptr_inc(b_wr_q);
    end
    if (pop) begin
      b_rd_d = ptr_inc(b_rd_q);
    end
    if (drop_hit) begin
      drop_d = drop_q - 1'b1;
    end

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      StFlush: if (drop_d == '0) state_d = StRun;
      default: state_d = StBoot;
    endcase

    // Redirect wins over any push/pop this cycle. A request accepted in the same cycle is
    // already owed by memory, so it is counted among the responses to drop.
    if (redirect_valid_i) begin
      pc_d    = redirect_aligned;
      osd_d   = '0;
      aq_wr_d = '0;
      aq_rd_d = '0;
      b_wr_d  = '0;
      b_rd_d  = '0;
      b_cnt_d = '0;
      b_we    = 1'b0;
      if (state_q == StFlush) begin
        // Keep the running drop count (already decremented for a response this cycle).
        state_d = (drop_d == '0) ? StRun : StFlush;
      end else begin
        drop_d  = osd_nxt;
        state_d = (osd_nxt == '0) ? StRun : StFlush;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      osd_q   <= '0;
      drop_q  <= '0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      osd_q   <= osd_d;
      drop_q  <= drop_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  // Storage is reset so id_pc_o/id_instr_o read as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        aq_mem[i] <= '0;
        bp_mem[i] <= '0;
        bi_mem[i] <= '0;
      end
    end else begin
      if (aq_we) begin
        aq_mem[aq_wr_q] <= pc_q;
      end
      if (b_we) begin
        bp_mem[b_wr_q] <= aq_mem[aq_rd_q];
        bi_mem[b_wr_q] <= imem_rsp_data_i;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_if_fetch_unit: self-checking bench for if_fetch_unit.
//
// A behavioural instruction memory answers every accepted request in order after a random
// latency, returning a word derived from the address. The reference model only knows the
// architectural rules: requests walk sequentially from the current fetch target, the stream
// seen by IF/ID is sequential from the last redirect target with matching words, and new-path
// accepted minus popped never exceeds DEPTH.
// ---------------------------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int unsigned   DEPTH    = 2;
  localparam logic [31:0]   RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  if_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid_o(imem_req_valid),
    .imem_req_addr_o (imem_req_addr),
    .imem_req_ready_i(imem_req_ready),
    .imem_rsp_valid_i(imem_rsp_valid),
    .imem_rsp_data_i (imem_rsp_data),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_pc_o         (id_pc),
    .id_instr_o      (id_instr)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_fault_o   (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic [31:0] exp_pc, req_exp;
  int          acc_since, pop_since, n_req, n_pop;
  bit          chk_idv_low = 1'b0;
  bit          faulted = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_restart(input logic [31:0] tgt);
    exp_pc    = {tgt[31:2], 2'b00};
    req_exp   = {tgt[31:2], 2'b00};
    acc_since = 0;
    pop_since = 0;
  endtask

  // One clock: sample at negedge, check against the model, drive inputs for the next posedge.
  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] tgt);
    bit    fire, pop;
    mreq_t m;
    @(negedge clk);
    cyc++;
    if (chk_idv_low) begin
      chk32("id_valid_after_redirect", {31'b0, id_valid}, 32'd0);
      chk_idv_low = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = tgt;
    fire = imem_req_valid && rdy;
    pop  = id_valid && idr && !redir;
    if (fire) begin
      if (faulted) chk32("no_request_after_fault", 32'd1, 32'd0);
      chk32("req_addr", imem_req_addr, req_exp);
      req_exp = req_exp + 32'd4;
      m.addr  = imem_req_addr;
      m.due   = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
      mq.push_back(m);
      acc_since++;
      n_req++;
    end
    if (pop) begin
      chk32("id_pc", id_pc, exp_pc);
      chk32("id_instr", id_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pop_since++;
      n_pop++;
    end
    if (acc_since - pop_since > int'(DEPTH)) begin
      chk32("occupancy_bound", 32'(acc_since - pop_since), 32'(DEPTH));
    end
    if (redir) begin
      model_restart(tgt);
      chk_idv_low = 1'b1;
`ifdef MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) faulted = 1'b1;
`endif
    end
  endtask

  task automatic do_reset(input bit stale);
    mreq_t m;
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    #1;
    chk32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk32("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk32("rst_id_pc", id_pc, 32'd0);
    chk32("rst_id_instr", id_instr, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk32("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    model_restart(RESET_PC);
    chk_idv_low = 1'b0;
    faulted     = 1'b0;
    n_req       = 0;
    n_pop       = 0;
    if (stale) begin
      // A response left over from before reset lands in the first cycle after release.
      m.addr = 32'hDEAD_BEE0;
      m.due  = 0;
      mq.push_back(m);
    end
  endtask

  initial begin
    logic [31:0] held_pc, held_instr, tgt;
    int          k;

    // Reset release with a 1-cycle memory: requests and ID stream 0x0, 0x4, 0x8, ...
    do_reset(1'b0);
    lat_lo = 0;
    lat_hi = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk32("stream_progress", 32'(n_pop >= 3), 32'd1);

    // IF/ID stall for 5 cycles: head entry held, occupancy bounded, nothing lost afterwards.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    held_pc    = id_pc;
    held_instr = id_instr;
    chk32("stall_id_valid", {31'b0, id_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk32("stall_id_pc_stable", id_pc, held_pc);
      chk32("stall_id_instr_stable", id_instr, held_instr);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect to 0x100 with two requests outstanding: both old responses dropped.
    lat_lo = 4;
    lat_hi = 4;
    k = 0;
    while (mq.size() != 2 && k < 30) begin
      step(1'b1, 1'b1, 1'b0, '0);
      k++;
    end
    chk32("two_outstanding", 32'(mq.size()), 32'd2);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    lat_lo = 0;
    lat_hi = 2;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk32("redirect_stream_started", 32'(pop_since >= 1), 32'd1);

    // Address wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ...
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom), 1'b0, '0);
    chk32("wrap_reached", 32'(acc_since >= 3), 32'd1);

    // Misaligned redirect to 0x102.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
`ifdef MISALIGN_TRAP_EN
    chk32("fetch_fault_set", {31'b0, fetch_fault}, 32'd1);
    chk32("no_fetch_after_fault", 32'(acc_since), 32'd0);
    do_reset(1'b0);
`else
    chk32("misaligned_fetch_progress", 32'(pop_since >= 2), 32'd1);
`endif

    // Random traffic with occasional aligned redirects.
    for (int i = 0; i < 500; i++) begin
      lat_lo = 0;
      lat_hi = int'($urandom_range(3, 0));
      if ($urandom_range(15, 0) == 0) begin
        tgt = $urandom & 32'hFFFF_FFFC;
        step(1'($urandom), 1'($urandom), 1'b1, tgt);
      end else begin
        step(1'($urandom), 1'($urandom), 1'b0, '0);
      end
    end
    chk32("random_progress", 32'(n_pop > 20), 32'd1);

    // Reset pulse during FLUSH, then a stale response right after release.
    lat_lo = 5;
    lat_hi = 5;
    k = 0;
    while (mq.size() == 0 && k < 30) begin
      step(1'b1, 1'b1, 1'b0, '0);
      k++;
    end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b1, 1'b0, '0);
    do_reset(1'b1);
    lat_lo = 0;
    lat_hi = 1;
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk32("post_reset_requests", 32'(n_req >= 2), 32'd1);
    chk32("post_reset_pops", 32'(n_pop >= 2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: capacity of the fetch buffer; maximum requests outstanding plus buffered.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  32  fetch address, word aligned.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  instruction word returned; in order; at most one per cycle; latency at least 1 cycle.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch or jump redirect from a later stage.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 id_valid  output  1  id_pc and id_instr are valid toward the IF/ID register.
REQ-013 id_ready  input  1  IF/ID register accepts this cycle; low means stall.
REQ-014 id_pc  output  32  PC of the presented instruction.
REQ-015 id_instr  output  32  presented instruction word.
REQ-016 fetch_fault  output  1  misaligned redirect flag (present only under MISALIGN_TRAP_EN).

Function
REQ-017 The request handshake SHALL complete on imem_req_valid && imem_req_ready; on completion pc advances by 4 (modulo 2^32, wrapping from 32'hFFFF_FFFC to 0).
REQ-018 imem_req_valid SHALL be asserted only in RUN while outstanding+buffered < DEPTH, and SHALL hold imem_req_addr stable until accepted.
REQ-019 Each accepted request's address SHALL be queued in order; each non-dropped response SHALL be written into the buffer paired with that address.
REQ-020 id_valid SHALL be high when the buffer is non-empty, showing the oldest entry; a pop SHALL occur on id_valid && id_ready.
REQ-021 When the buffer is full, no request SHALL issue; a pop and a push in the same cycle SHALL both take effect.
REQ-022 The FSM SHALL have three states: BOOT -> RUN after one cycle; RUN -> FLUSH on redirect_valid while outstanding > 0; RUN stays in RUN on redirect_valid with outstanding == 0; FLUSH -> RUN when the drop count reaches 0.
REQ-023 On redirect_valid, in the same edge, the block SHALL: set pc to {redirect_pc[31:2],2'b00}; empty the buffer; load drop count = outstanding minus any response arriving that cycle; cancel any request not yet accepted.
REQ-024 While in FLUSH, each imem_rsp_valid SHALL decrement the drop count without a buffer write, and no request SHALL issue.
REQ-025 A redirect while in FLUSH SHALL reload pc and keep the current drop count; redirect SHALL take priority over a simultaneous pop or push.
REQ-026 id_valid SHALL be low in the cycle after a redirect.

Reset
REQ-027 On rst: pc=RESET_PC, state=BOOT, buffer empty, outstanding=0, drop count=0, imem_req_valid=0, id_valid=0, id_pc=0, id_instr=0, fetch_fault=0.
REQ-028 Assertion of rst mid-transaction SHALL discard all in-flight state; responses arriving after reset release SHALL be ignored until a request has issued.

Configuration
REQ-029 With MISALIGN_TRAP_EN defined: on a redirect with redirect_pc[1:0]!=0, the block SHALL set fetch_fault=1 (sticky until rst), enter FLUSH or RUN per REQ-022, and issue no further requests.
REQ-030 Without MISALIGN_TRAP_EN: fetch_fault is absent and low bits of redirect_pc are silently cleared.

Verification
REQ-031 Reset release, imem_req_ready=1, 1-cycle memory -> requests at 0x0, 0x4, 0x8; id_pc sequence 0x0, 0x4, 0x8 with matching words.
REQ-032 id_ready=0 for 5 cycles -> at most DEPTH requests outstanding or buffered; id_pc/id_instr held stable; no entry lost after release.
REQ-033 Redirect to 0x100 with 2 requests outstanding -> both responses dropped; next id_pc=0x100.
REQ-034 pc=0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-035 Redirect to 0x102 with MISALIGN_TRAP_EN -> fetch_fault=1 and no further requests; without it -> fetch from 0x100.
REQ-036 rst pulse during FLUSH -> all outputs at reset values; first request to RESET_PC.
